// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared constants and the in-flight tag type for fp_convert_arbiter.
package fp_arb_pkg;
    localparam int FP_CVT_LATENCY = 6;
    localparam int FP_WIDTH       = 32;
    // Index wide enough for the largest supported requester count (8).
    localparam int FP_IDX_W       = 3;
    typedef struct packed {
        logic                valid;
        logic [FP_IDX_W-1:0] index;
    } fp_tag_t;
endpackage

// File: rtl/fp_convert_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker; nearest eligible requester at or above ptr wins.
module rr_grant
    import fp_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        elig,
    input  logic [FP_IDX_W-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [FP_IDX_W-1:0] idx
);
    int best, d;
    always_comb begin
        best  = N;
        d     = 0;
        idx   = '0;
        grant = '0;
        // Distance from ptr with wrap; smallest distance has priority.
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(ptr)) % N;
            if (elig[i] && d < best) begin
                best = d;
                idx  = FP_IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) grant[i] = best < N && idx == FP_IDX_W'(i);
    end
endmodule

// File: rtl/fp_convert_arbiter.sv
// fp_convert_arbiter: round-robin sharing of one fixed-latency int-to-float converter.
// Optional macro FP_CONVERT_ARB_CHECK_EN adds a sticky err flag for done/tag misalignment.
module fp_convert_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LATENCY      = FP_CVT_LATENCY,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fpu_go,
    output logic [FP_WIDTH-1:0]         fpu_in,
    input  logic                        fpu_done,
    input  logic [FP_WIDTH-1:0]         fpu_out,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [FP_WIDTH-1:0]         rsp_data
`ifdef FP_CONVERT_ARB_CHECK_EN
    ,
    output logic                        err
`endif
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [FP_IDX_W-1:0] ptr, gidx;
    logic [NUM_REQ-1:0]  elig, ret;
    logic [CW-1:0]       cnt [NUM_REQ];
    fp_tag_t             tag [LATENCY];
    fp_tag_t             last;

    // Grants are suppressed during reset so nothing is issued into a discarded tag chain.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = reset && req_valid[i] && cnt[i] < CW'(MAX_INFLIGHT);
    end

    rr_grant #(.N(NUM_REQ)) u_rr (
        .elig  (elig),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gidx)
    );

    assign fpu_go = |req_ready;
    assign fpu_in = fpu_go ? req_data[gidx*FP_WIDTH +: FP_WIDTH] : '0;
    assign last   = tag[LATENCY-1];

    always_comb begin
        ret = '0;
        for (int i = 0; i < NUM_REQ; i++) ret[i] = last.valid && last.index == FP_IDX_W'(i);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int k = 0; k < LATENCY; k++) tag[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            if (fpu_go) ptr <= (gidx == FP_IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            tag[0] <= fpu_go ? fp_tag_t'{valid: 1'b1, index: gidx} : '0;
            for (int k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];
            rsp_valid <= ret;
            if (last.valid) rsp_data <= fpu_out;
            // Simultaneous issue and retire leave the count unchanged.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && !ret[i]) cnt[i] <= cnt[i] + 1'b1;
                else if (ret[i] && !req_ready[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

`ifdef FP_CONVERT_ARB_CHECK_EN
    localparam int MW = $clog2(LATENCY + 1);
    logic [MW-1:0] mask;
    // Results from before reset may still emerge; ignore the compare until they drain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mask <= MW'(LATENCY);
            err  <= 1'b0;
        end else begin
            if (mask != '0) mask <= mask - 1'b1;
            if (mask == '0 && fpu_done != last.valid) err <= 1'b1;
        end
    end
`else
    logic unused_done;
    assign unused_done = fpu_done;
`endif
endmodule

// File: tb/tb_fp_convert_arbiter.sv
// tb_fp_convert_arbiter: randomized and directed checks against a queue-based reference model.
module tb_fp_convert_arbiter;
    localparam int N  = 4;
    localparam int L  = 6;
    localparam int MI = 4;

    logic          clock = 0;
    logic          reset = 0;
    logic [N-1:0]  req_valid = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          fpu_go;
    logic [31:0]   fpu_in;
    logic          fpu_done;
    logic [31:0]   fpu_out;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_data;
    logic          err;
    logic          force_done = 0;

    int checks = 0;
    int errors = 0;

    fp_convert_arbiter #(.NUM_REQ(N), .LATENCY(L), .MAX_INFLIGHT(MI)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fpu_go    (fpu_go),
        .fpu_in    (fpu_in),
        .fpu_done  (fpu_done),
        .fpu_out   (fpu_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
`ifdef FP_CONVERT_ARB_CHECK_EN
        ,
        .err       (err)
`endif
    );

`ifndef FP_CONVERT_ARB_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clock = ~clock;

    // Int32 to IEEE single, round to nearest even.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [63:0] m, keep, rem, half;
        int          p, e, sh;
        if (x == 0) return 32'h0;
        s = x[31];
        m = s ? 64'(-$signed({32'hFFFFFFFF, x})) : 64'(x);
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = 127 + p;
        if (p <= 23) keep = m << (23 - p);
        else begin
            sh   = p - 23;
            keep = m >> sh;
            rem  = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == (64'd1 << 24)) begin
                keep = keep >> 1;
                e++;
            end
        end
        return {s, 8'(e), keep[22:0]};
    endfunction

    // Converter stand-in: fixed latency, not reset, so stale results can emerge after reset.
    logic [L-1:0]       pg = '0;
    logic [L-1:0][31:0] pd = '0;
    always @(posedge clock) begin
        pg <= {pg[L-2:0], fpu_go};
        pd <= {pd[L-2:0], i2f(fpu_in)};
    end
    assign fpu_done = pg[L-1] | force_done;
    assign fpu_out  = pd[L-1];

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] data;
    } rsp_t;
    rsp_t        pend[$];
    int          m_ptr = 0;
    int          m_cnt[N];
    int          cyc = 0;
    logic [N-1:0] exp_rv = '0;
    logic [31:0] exp_rd = '0;

    function automatic int pick();
        int j;
        if (!reset) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j] && m_cnt[j] < MI) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick();
        return g < 0 ? '0 : N'(1 << g);
    endfunction

    function automatic logic [31:0] exp_in();
        int g;
        g = pick();
        return g < 0 ? 32'h0 : req_data[g*32 +: 32];
    endfunction

    task automatic tick();
        int   g;
        rsp_t r;
        g = pick();
        @(posedge clock);
        if (!reset) begin
            m_ptr = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            pend.delete();
            exp_rd = '0;
        end else if (g >= 0) begin
            pend.push_back('{cyc + L + 1, g, i2f(req_data[g*32 +: 32])});
            m_cnt[g]++;
            m_ptr = (g + 1) % N;
        end
        cyc++;
        exp_rv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_rv = N'(1 << r.idx);
            exp_rd = r.data;
            m_cnt[r.idx]--;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 0;
        req_valid = '0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        req_valid = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 4;
            if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
            if (fpu_go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", fpu_go); end
            if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
            if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
            tick();
        end
        reset = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL release_ready got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        int got_k;
        logic [N-1:0] got_v;
        logic [31:0] got_d;
        do_reset();
        got_k = -1;
        got_v = '0;
        got_d = '0;
        req_valid = 4'b0100;
        req_data[64 +: 32] = 32'h7;
        #1;
        checks += 3;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        if (fpu_go !== 1'b1) begin errors++; $display("FAIL single_go got %b want 1", fpu_go); end
        if (fpu_in !== 32'h7) begin errors++; $display("FAIL single_in got %h want 7", fpu_in); end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (rsp_valid !== '0 && got_k < 0) begin
                got_k = k;
                got_v = rsp_valid;
                got_d = rsp_data;
            end
            tick();
        end
        checks += 3;
        if (got_k !== 7) begin errors++; $display("FAIL single_latency got %0d want 7", got_k); end
        if (got_v !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b want 0100", got_v); end
        if (got_d !== i2f(32'h7) || got_d !== 32'h40E00000)
            begin errors++; $display("FAIL single_rsp_data got %h want 40e00000", got_d); end
    endtask

    task automatic test_fairness();
        int order[$];
        do_reset();
        for (int k = 0; k < 24; k++) begin
            req_valid = k < 8 ? 4'hF : 4'h0;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (k < 8) begin
                checks++;
                if (req_ready !== N'(1 << (k % N)))
                    begin errors++; $display("FAIL fair_grant cycle %0d got %b want %b", k, req_ready, N'(1 << (k % N))); end
            end
            checks += 2;
            if (rsp_valid !== exp_rv) begin errors++; $display("FAIL fair_rsp_valid cycle %0d got %b want %b", k, rsp_valid, exp_rv); end
            if (rsp_data !== exp_rd) begin errors++; $display("FAIL fair_rsp_data cycle %0d got %h want %h", k, rsp_data, exp_rd); end
            for (int i = 0; i < N; i++) if (rsp_valid[i]) order.push_back(i);
            tick();
        end
        checks++;
        if (order.size() != 8) begin errors++; $display("FAIL fair_count got %0d want 8", order.size()); end
        for (int j = 0; j < order.size() && j < 8; j++) begin
            checks++;
            if (order[j] != j % N) begin errors++; $display("FAIL fair_order slot %0d got %0d want %0d", j, order[j], j % N); end
        end
    endtask

    task automatic test_throttle();
        logic [9:0] tbl;
        tbl = 10'b1110001111;
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            req_data[32 +: 32] = $urandom;
            #1;
            checks += 2;
            if (req_ready[1] !== tbl[k]) begin errors++; $display("FAIL throttle_ready cycle %0d got %b want %b", k, req_ready[1], tbl[k]); end
            if (req_ready !== exp_ready()) begin errors++; $display("FAIL throttle_model cycle %0d got %b want %b", k, req_ready, exp_ready()); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_midflight();
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            req_data[31:0] = $urandom;
            #1;
            checks++;
            if (fpu_go !== 1'b1) begin errors++; $display("FAIL mid_issue cycle %0d got %b want 1", k, fpu_go); end
            tick();
        end
        req_valid = '0;
        reset = 0;
        tick();
        tick();
        reset = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks += 2;
            if (rsp_valid !== '0) begin errors++; $display("FAIL mid_dropped cycle %0d got %b want 0", k, rsp_valid); end
            if (err !== 1'b0) begin errors++; $display("FAIL mid_err cycle %0d got %b want 0", k, err); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom_range(0, 15)) | (k % 50 < 20 ? 4'hF : 4'h0);
            for (int i = 0; i < N; i++)
                case ($urandom_range(0, 7))
                    0: req_data[i*32 +: 32] = 32'h80000000;
                    1: req_data[i*32 +: 32] = 32'hFFFFFFFF;
                    2: req_data[i*32 +: 32] = 32'h0;
                    default: req_data[i*32 +: 32] = $urandom;
                endcase
            #1;
            checks += 5;
            if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want %b", k, req_ready, exp_ready()); end
            if (fpu_go !== (exp_ready() != 0)) begin errors++; $display("FAIL rnd_go cycle %0d got %b", k, fpu_go); end
            if (fpu_in !== exp_in()) begin errors++; $display("FAIL rnd_in cycle %0d got %h want %h", k, fpu_in, exp_in()); end
            if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid cycle %0d got %b want %b", k, rsp_valid, exp_rv); end
            if (rsp_data !== exp_rd) begin errors++; $display("FAIL rnd_rsp_data cycle %0d got %h want %h", k, rsp_data, exp_rd); end
            tick();
        end
        req_valid = '0;
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got %b want 0", err); end
    endtask

`ifdef FP_CONVERT_ARB_CHECK_EN
    task automatic test_check();
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL chk_idle got %b want 0", err); end
        force_done = 1;
        tick();
        force_done = 0;
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL chk_set got %b want 1", err); end
        for (int k = 0; k < 3; k++) tick();
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL chk_sticky got %b want 1", err); end
        reset = 0;
        tick();
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL chk_clear got %b want 0", err); end
        reset = 1;
    endtask
`endif

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        test_reset();
        test_single();
        test_fairness();
        test_throttle();
        test_midflight();
        test_random();
`ifdef FP_CONVERT_ARB_CHECK_EN
        test_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
